// File: rtl/amba_apb_bridge.sv
// APB slave to byte-wide peripheral register bridge.
// One APB transfer becomes one write or read strobe held until the peripheral acks.
module amba_apb_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        pen,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        bus2ip_clk,
  output logic [1:0]  bus2ip_addr,
  output logic [8:0]  bus2ip_data,
  output logic        bus2ip_wr,
  output logic        bus2ip_rd,
  input  logic [7:0]  ip2bus_data,
  input  logic        ip2bus_rdack,
  input  logic        ip2bus_wrack
);

  localparam int unsigned APB_W   = 32;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned WDATA_W = 9;
  localparam int unsigned RDATA_W = 8;
  localparam int unsigned PAD_W   = APB_W - RDATA_W;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               dir_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WDATA_W-1:0] wdata_q;
  logic [APB_W-1:0]   prdata_q;

  logic               in_access_c;
  logic               ack_c;
  logic               pready_c;
  logic               setup_c;
  logic               rd_done_c;
  logic [APB_W-1:0]   rd_word_c;

  // Only the register offset and the 9-bit write payload are meaningful.
  logic unused_apb_bits;
  assign unused_apb_bits = ^{addr[APB_W-1:ADDR_W], pwdata[APB_W-1:WDATA_W]};

  assign bus2ip_clk = clk;

  // Transfer qualifiers shared by the FSM and the datapath.
  always_comb begin
    in_access_c = (state_q == ACCESS);
    ack_c       = dir_q ? ip2bus_wrack : ip2bus_rdack;
    pready_c    = in_access_c & psel & pen & ack_c;
    setup_c     = (state_q == IDLE) & psel;
    rd_done_c   = pready_c & ~dir_q;
    rd_word_c   = {{PAD_W{1'b0}}, ip2bus_data};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a dropped psel in ACCESS is a master abort.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (psel) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (pready_c || !psel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; strobes decode only registered state so they cannot glitch.
  always_comb begin
    bus2ip_wr   = 1'b0;
    bus2ip_rd   = 1'b0;
    pready      = 1'b0;
    prdata      = prdata_q;
    bus2ip_addr = addr_q;
    bus2ip_data = wdata_q;
    if (in_access_c) begin
      bus2ip_wr = dir_q;
      bus2ip_rd = ~dir_q;
      pready    = pready_c;
    end
    if (rd_done_c) begin
      prdata = rd_word_c;
    end
  end

  // Request capture, only from IDLE so APB changes during ACCESS are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      dir_q   <= 1'b0;
    end else if (setup_c) begin
      addr_q  <= addr[ADDR_W-1:0];
      wdata_q <= pwdata[WDATA_W-1:0];
      dir_q   <= pwrite;
    end
  end

  // Last completed read value, held across idle and aborted transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prdata_q <= '0;
    end else if (rd_done_c) begin
      prdata_q <= rd_word_c;
    end
  end

endmodule

// File: tb/tb_amba_apb_bridge.sv
// Scoreboard bench for amba_apb_bridge: expected transfers queued at setup,
// popped and compared whenever the bridge raises pready.
module tb_amba_apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        pwrite;
  logic        psel;
  logic        pen;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        bus2ip_clk;
  logic [1:0]  bus2ip_addr;
  logic [8:0]  bus2ip_data;
  logic        bus2ip_wr;
  logic        bus2ip_rd;
  logic [7:0]  ip2bus_data;
  logic        ip2bus_rdack;
  logic        ip2bus_wrack;

  always #5 clk = ~clk;

  amba_apb_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .pwrite       (pwrite),
    .psel         (psel),
    .pen          (pen),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .bus2ip_clk   (bus2ip_clk),
    .bus2ip_addr  (bus2ip_addr),
    .bus2ip_data  (bus2ip_data),
    .bus2ip_wr    (bus2ip_wr),
    .bus2ip_rd    (bus2ip_rd),
    .ip2bus_data  (ip2bus_data),
    .ip2bus_rdack (ip2bus_rdack),
    .ip2bus_wrack (ip2bus_wrack)
  );

  typedef struct {
    logic [1:0] a;
    logic [8:0] d;
    logic       wr;
    logic [7:0] rd;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp  = 0;
  int         n_err  = 0;
  int         n_done = 0;
  int         n_exp  = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Completion monitor: every pready must match the oldest queued transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1 && pready === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_addr", 32'(bus2ip_addr), 32'(e.a));
        check("done_data", 32'(bus2ip_data), 32'(e.d));
        check("done_wr", 32'(bus2ip_wr), 32'(e.wr));
        check("done_rd", 32'(bus2ip_rd), 32'(!e.wr));
        if (!e.wr) check("done_prdata", prdata, {24'h0, e.rd});
        n_done++;
      end
    end
  end

  task automatic drive_idle();
    psel = 1'b0; pen = 1'b0; ip2bus_wrack = 1'b0; ip2bus_rdack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_idle();
      addr = $urandom; pwdata = $urandom; ip2bus_data = 8'($urandom);
      @(negedge clk);
      check("idle_wr", 32'(bus2ip_wr), 32'd0);
      check("idle_rd", 32'(bus2ip_rd), 32'd0);
      check("idle_pready", 32'(pready), 32'd0);
      check("idle_prdata", prdata, {24'h0, last_rd});
    end
  endtask

  // One APB transfer: setup phase, then waits+1 access cycles, ack in the last.
  task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                      input int waits, input logic [7:0] rdv);
    exp_t e;
    int   wr_cyc;
    wr_cyc = 0;
    @(posedge clk); #1;
    addr = a; pwdata = wd; pwrite = w; psel = 1'b1; pen = 1'b0;
    ip2bus_wrack = 1'b0; ip2bus_rdack = 1'b0;
    @(negedge clk);
    check("setup_wr", 32'(bus2ip_wr), 32'd0);
    check("setup_rd", 32'(bus2ip_rd), 32'd0);
    check("setup_pready", 32'(pready), 32'd0);
    check("setup_prdata", prdata, {24'h0, last_rd});
    e.a = a[1:0]; e.d = wd[8:0]; e.wr = w; e.rd = rdv;
    sb.push_back(e);
    n_exp++;
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      pen = 1'b1;
      if (i > 0) begin
        addr = $urandom; pwdata = $urandom;
      end
      ip2bus_data  = (i == waits) ? rdv : 8'($urandom);
      ip2bus_wrack = w && (i == waits);
      ip2bus_rdack = !w && (i == waits);
      @(negedge clk);
      if (bus2ip_wr) wr_cyc++;
      check("acc_wr", 32'(bus2ip_wr), 32'(w));
      check("acc_rd", 32'(bus2ip_rd), 32'(!w));
      check("acc_pready", 32'(pready), 32'(i == waits));
      if (i < waits) check("wait_prdata", prdata, {24'h0, last_rd});
    end
    check("wr_cycles", 32'(wr_cyc), w ? 32'(waits + 1) : 32'd0);
    if (!w) last_rd = rdv;
  endtask

  initial begin
    rst = 1'b0;
    addr = '0; pwdata = '0; pwrite = 1'b0; ip2bus_data = '0;
    drive_idle();

    // Reset held with busy inputs: everything quiet, clock passes through.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      psel = 1'b1; pen = 1'($urandom_range(0, 1)); pwrite = 1'($urandom_range(0, 1));
      ip2bus_wrack = 1'b1; ip2bus_rdack = 1'b1;
      addr = $urandom; pwdata = $urandom; ip2bus_data = 8'($urandom);
      check("rst_clk_hi", 32'(bus2ip_clk), 32'd1);
      @(negedge clk);
      check("rst_clk_lo", 32'(bus2ip_clk), 32'd0);
      check("rst_wr", 32'(bus2ip_wr), 32'd0);
      check("rst_rd", 32'(bus2ip_rd), 32'd0);
      check("rst_pready", 32'(pready), 32'd0);
      check("rst_prdata", prdata, 32'd0);
      check("rst_addr", 32'(bus2ip_addr), 32'd0);
      check("rst_data", 32'(bus2ip_data), 32'd0);
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b1;

    // Acks while idle never complete anything.
    @(posedge clk); #1;
    pen = 1'b1; ip2bus_wrack = 1'b1; ip2bus_rdack = 1'b1;
    @(negedge clk);
    check("idle_ack_pready", 32'(pready), 32'd0);
    check("idle_ack_wr", 32'(bus2ip_wr), 32'd0);
    idle(1);

    xfer(32'h0, 32'h1111, 1'b1, 0, 8'h00);
    idle(1);
    xfer(32'h1, 32'hFFFF, 1'b1, 2, 8'h00);
    idle(1);
    xfer(32'h2, 32'h0, 1'b0, 0, 8'h0F);
    idle(2);

    // Back-to-back, each with its own setup phase.
    xfer(32'h3, 32'h0AB, 1'b1, 1, 8'h00);
    xfer(32'h1, 32'h0, 1'b0, 2, 8'hC3);
    xfer(32'h2, 32'h100, 1'b1, 0, 8'h00);
    idle(1);

    // Pending read: no pen, then wrong-direction ack, then abort with rdack.
    @(posedge clk); #1;
    addr = 32'h3; pwrite = 1'b0; psel = 1'b1; pen = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    ip2bus_rdack = 1'b1; ip2bus_data = 8'hAA;
    @(negedge clk);
    check("nopen_pready", 32'(pready), 32'd0);
    check("nopen_rd", 32'(bus2ip_rd), 32'd1);
    @(posedge clk); #1;
    pen = 1'b1; ip2bus_rdack = 1'b0; ip2bus_wrack = 1'b1;
    @(negedge clk);
    check("wrongack_pready", 32'(pready), 32'd0);
    check("wrongack_rd", 32'(bus2ip_rd), 32'd1);
    check("wrongack_prdata", prdata, {24'h0, last_rd});
    @(posedge clk); #1;
    psel = 1'b0; ip2bus_wrack = 1'b0; ip2bus_rdack = 1'b1;
    @(negedge clk);
    check("abort_pready", 32'(pready), 32'd0);
    check("abort_addr", 32'(bus2ip_addr), 32'd3);
    idle(2);

    for (int k = 0; k < 8; k++) begin
      xfer($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom));
      if (k[0]) idle(1);
    end
    idle(1);

    // Asynchronous reset in the middle of an access.
    @(posedge clk); #1;
    addr = 32'h1; pwdata = 32'h155; pwrite = 1'b1; psel = 1'b1; pen = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    pen = 1'b1;
    @(negedge clk);
    check("pre_arst_wr", 32'(bus2ip_wr), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_wr", 32'(bus2ip_wr), 32'd0);
    check("arst_rd", 32'(bus2ip_rd), 32'd0);
    check("arst_pready", 32'(pready), 32'd0);
    check("arst_addr", 32'(bus2ip_addr), 32'd0);
    check("arst_data", 32'(bus2ip_data), 32'd0);
    check("arst_prdata", prdata, 32'd0);
    last_rd = 8'h00;
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    xfer(32'h2, 32'h0, 1'b0, 1, 8'h5A);
    idle(2);

    check("sb_left", 32'(sb.size()), 32'd0);
    check("n_done", 32'(n_done), 32'(n_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/amba_apb_bridge.md
# amba_apb_bridge

APB slave to simple IP-bus bridge (module `amba_apb_bridge`). It converts one APB transfer into a write or read strobe toward an 8-bit peripheral register interface, such as the SPI ROM controller. It completes the APB transfer when the peripheral acknowledges. It sits between the system APB interconnect and a single peripheral with four byte-wide registers.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `addr`  in  32  APB address; only `addr[1:0]` is used.
- `pwrite`  in  1  APB direction (1 = write).
- `psel`  in  1  APB select.
- `pen`  in  1  APB enable (access phase).
- `pwdata`  in  32  APB write data; only `pwdata[8:0]` is used.
- `prdata`  out  32  APB read data, `{23'b0, 1'b0, byte}`, i.e. zero-extended 8-bit read value.
- `pready`  out  1  APB transfer complete.
- `bus2ip_clk`  out  1  peripheral clock, equal to `clk` (pass-through).
- `bus2ip_addr`  out  2  latched register address.
- `bus2ip_data`  out  9  latched write data, `pwdata[8:0]`.
- `bus2ip_wr`  out  1  write strobe.
- `bus2ip_rd`  out  1  read strobe.
- `ip2bus_data`  in  8  peripheral read data.
- `ip2bus_rdack`  in  1  read acknowledge.
- `ip2bus_wrack`  in  1  write acknowledge.

## Operation
- FSM has two states.
- **IDLE**
  - On a rising edge with `psel`=1: latch `addr[1:0]` into `bus2ip_addr`, `pwdata[8:0]` into `bus2ip_data` and `pwrite` into `dir_q`, then go to ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**
  - `bus2ip_wr` = `dir_q`; `bus2ip_rd` = `~dir_q`. Both are decoded from registered state only, so they are glitch-free.
  - `ack` = `dir_q ? ip2bus_wrack : ip2bus_rdack`. The acknowledge of the opposite direction is ignored.
  - `pready` = `psel & pen & ack`, combinational.
  - Rising edge with `pready`=1: the transfer completes; go to IDLE. On a read, load `prdata_q` with `{24'b0, ip2bus_data}`.
  - Rising edge with `psel`=0 (master abort): go to IDLE. No `pready`; `prdata_q` is unchanged.
  - Any other edge: stay in ACCESS (wait state). Strobes stay high and the latched address/data are held.
- `prdata` = `{24'b0, ip2bus_data}` while `pready` is high on a read; otherwise `prdata_q`.
- Acks seen while in IDLE are ignored and produce no `pready`.
- Address/data are only re-latched from IDLE. APB signals changing during ACCESS do not alter `bus2ip_addr`/`bus2ip_data`.

## Timing
- Reset (`rst`=0, asynchronous):
  - state = IDLE.
  - `bus2ip_addr`=0, `bus2ip_data`=0, `dir_q`=0, `prdata_q`=0.
  - Outputs: `bus2ip_wr`=0, `bus2ip_rd`=0, `pready`=0, `prdata`=0.
  - `bus2ip_clk` follows `clk` even in reset.
- Reset asserted mid-transfer: immediate return to IDLE, strobes drop at once, transfer is lost.
- Strobes rise one `clk` edge after `psel` is first sampled high (the setup-phase edge).
- Zero-wait transfer: the ack arrives in the first ACCESS cycle together with `pen`. `pready` is high for exactly that cycle; strobes drop on the following edge.
- Wait states: each ACCESS cycle without ack adds one cycle. There is no timeout.
- A transfer takes a minimum of 2 cycles: setup plus access.
- Back-to-back transfers: after completion the FSM is in IDLE for at least the edge at which the new `psel` is sampled. A new transfer therefore needs its own setup phase.

## Test plan
- **Reset:** hold `rst`=0 with toggling inputs -> all outputs 0 except `bus2ip_clk`; state stays IDLE.
- **Zero-wait write:**
  - Stimulus: `addr`=0, `pwdata`=0x1111, `pwrite`=1; `psel` for one cycle, then `pen`+`ip2bus_wrack` for one cycle.
  - Required: `bus2ip_addr`=0, `bus2ip_data`=0x111, `bus2ip_wr` high 1 cycle, `pready` high 1 cycle, `bus2ip_rd` never high.
- **Wait-state write:**
  - Stimulus: `addr`=1, `pwdata`=0xFFFF; `pen` held 3 cycles, `ip2bus_wrack` only in the 3rd.
  - Required: `bus2ip_data`=0x1FF, `bus2ip_addr`=1, `bus2ip_wr` high 3 cycles, `pready` only in the 3rd cycle.
- **Read:**
  - Stimulus: `addr`=2, `pwrite`=0, `ip2bus_rdack`=1 with `ip2bus_data`=0x0F in the access cycle.
  - Required: `bus2ip_rd` high, `prdata`=0x0000000F with `pready`=1, `prdata` holds 0x0F after the transfer.
- **Wrong ack / abort:**
  - Stimulus: read pending with `ip2bus_wrack`=1 -> no `pready`. Then drop `psel`.
  - Required: FSM returns to IDLE, strobes drop, `prdata` unchanged.
- **Async reset mid-ACCESS:** assert `rst` low between edges -> strobes go low immediately, no `pready`.
